mdu_issue_sched: RTL

Sequencer and arbiter for the shared multiply/divide path of the execute-stage ALU. Two issue slots compete for the one combinational multiplier/divider. The block grants one request at a time in round-robin order and holds that request's opcode and operands stable for a fixed number of cycles, which makes the long mul/div paths legal multicycle paths. It then registers the result and error flag and returns them over a valid/ready handshake to the completion stage.

---
 rtl/mdu_issue_sched.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/mdu_issue_sched.sv
// mdu_issue_sched: round-robin issue of two request slots onto the shared
// multiply/divide unit. The granted opcode and operands are held constant on
// the unit for a fixed per-class window. This makes the long mul/div paths
// legal multicycle paths. The result is then registered and handed back over
// a valid/ready handshake.
//
// state | meaning
// IDLE  | no work in flight; grants at most one slot per cycle
// EXEC  | operands held on the shared unit; cnt counts down the hold window
// DONE  | result registered; res_valid high until res_ready
module mdu_issue_sched #(
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [5:0]  req0_aluop,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [4:0]  req0_rd,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [5:0]  req1_aluop,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [4:0]  req1_rd,
    output logic [5:0]  alu_op,
    output logic [31:0] alu_in1,
    output logic [31:0] alu_in2,
    input  logic [31:0] alu_out,
    input  logic        alu_error,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic [4:0]  res_rd,
    output logic        res_src,
    output logic        res_error,
    output logic        busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // The counter reload is one less than the hold count, so EXEC lasts LAT cycles.
    localparam logic [3:0] MUL_HOLD = 4'(MUL_LAT - 1);
    localparam logic [3:0] DIV_HOLD = 4'(DIV_LAT - 1);

    logic [1:0]  state;
    logic [3:0]  cnt;
    logic        last;
    logic [5:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;

    logic        take0;
    logic        take1;
    logic [5:0]  sel_op;
    logic [31:0] sel_a;
    logic [31:0] sel_b;
    logic [4:0]  sel_rd;

    function automatic logic is_mul(input logic [5:0] op);
        return (op == 6'd16) || (op == 6'd17) || (op == 6'd18) || (op == 6'd22);
    endfunction

    function automatic logic is_div(input logic [5:0] op);
        return (op == 6'd24) || (op == 6'd26) || (op == 6'd28) || (op == 6'd30);
    endfunction

    // Round-robin grant and request mux. Ready is gated by rst_n so that it
    // reads 0 while reset is held, even if requesters keep valid asserted.
    always_comb begin
        take0  = 1'b0;
        take1  = 1'b0;
        sel_op = req0_aluop;
        sel_a  = req0_a;
        sel_b  = req0_b;
        sel_rd = req0_rd;
        if (rst_n && (state == S_IDLE)) begin
            take0 = req0_valid && (!req1_valid || last);
            take1 = req1_valid && (!req0_valid || !last);
        end
        if (take1) begin
            sel_op = req1_aluop;
            sel_a  = req1_a;
            sel_b  = req1_b;
            sel_rd = req1_rd;
        end
    end

    assign req0_ready = take0;
    assign req1_ready = take1;

    // Sequencer: accept and latch a request, hold it for the class window, then
    // register the unit's result. Illegal opcodes skip EXEC completely.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            last      <= 1'b1;
            op_q      <= 6'd0;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            res_data  <= 32'd0;
            res_rd    <= 5'd0;
            res_src   <= 1'b0;
            res_error <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (take0 || take1) begin
                        op_q    <= sel_op;
                        a_q     <= sel_a;
                        b_q     <= sel_b;
                        res_rd  <= sel_rd;
                        res_src <= take1;
                        last    <= take1;
                        if (is_mul(sel_op)) begin
                            cnt   <= MUL_HOLD;
                            state <= S_EXEC;
                        end else if (is_div(sel_op)) begin
                            cnt   <= DIV_HOLD;
                            state <= S_EXEC;
                        end else begin
                            res_data  <= 32'd0;
                            res_error <= 1'b1;
                            state     <= S_DONE;
                        end
                    end
                end
                S_EXEC: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        res_data  <= alu_out;
                        res_error <= alu_error;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (res_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // The shared unit sees the latched operands only during EXEC and zeros otherwise.
    always_comb begin
        alu_op  = 6'd0;
        alu_in1 = 32'd0;
        alu_in2 = 32'd0;
        if (state == S_EXEC) begin
            alu_op  = op_q;
            alu_in1 = a_q;
            alu_in2 = b_q;
        end
    end

    assign res_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);

endmodule
